// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer sitting between ID and IF_Stage.
// It issues fetch requests, freezes the PC on memory stalls and load-use
// hazards, holds a branch target while memory is busy, and traps into a
// sticky error state when instruction memory stops answering.
//
// Handshake: imem_req is the request, imem_ready the response. A cycle
// with imem_req=1 and imem_ready=1 completes a fetch; imem_req=1 with
// imem_ready=0 is a wait cycle and counts toward the timeout. imem_ready
// seen while imem_req=0 completes nothing but still clears the wait count.
module fetch_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branch_taken,
    input  logic [31:0]      branch_addr,
    input  logic             hazard,
    input  logic             imem_ready,
    output logic             imem_req,
    output logic             if_freeze,
    output logic             if_branch_taken,
    output logic [31:0]      if_branch_addr,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             timeout_err,
    output logic [1:0]       dbg_state
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_BR_PEND = 2'd2,
        S_ERR     = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       br_q, br_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              terr_q, terr_d;
    logic              wait_hit;
    logic              fsm_req;
    logic              fsm_freeze;

    // Next-state and output decode; reset forces the idle output pattern last.
    always_comb begin
        state_d         = state_q;
        br_d            = br_q;
        fsm_req         = 1'b0;
        fsm_freeze      = 1'b1;
        ifid_flush      = 1'b1;
        if_branch_taken = 1'b0;
        if_branch_addr  = branch_addr;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                fsm_req = 1'b1;
                if (branch_taken && imem_ready) begin
                    if_branch_taken = 1'b1;
                    fsm_freeze      = 1'b0;
                end else if (branch_taken) begin
                    // Memory busy: park the target until the word arrives.
                    br_d    = branch_addr;
                    state_d = S_BR_PEND;
                end else if (!imem_ready) begin
                    // Bubble into ID: freeze and flush stay at defaults.
                end else if (hazard) begin
                    ifid_flush = 1'b0;
                end else begin
                    fsm_freeze = 1'b0;
                    ifid_flush = 1'b0;
                end
            end
            S_BR_PEND: begin
                fsm_req        = 1'b1;
                if_branch_addr = br_q;
                if (imem_ready) begin
                    if_branch_taken = 1'b1;
                    fsm_freeze      = 1'b0;
                    state_d         = S_FETCH;
                end
            end
            default: begin
                // S_ERR: only reset leaves.
            end
        endcase

        // The timeout overrides every transition, and a branch that would
        // have been parked on this cycle is dropped.
        wait_hit = fsm_req && !imem_ready && (wait_q == WAIT_W'(TIMEOUT - 1));
        if (wait_hit) begin
            state_d = S_ERR;
            br_d    = br_q;
        end

        imem_req  = fsm_req;
        if_freeze = fsm_freeze;
        if (rst) begin
            imem_req        = 1'b0;
            if_freeze       = 1'b1;
            ifid_flush      = 1'b1;
            if_branch_taken = 1'b0;
            if_branch_addr  = branch_addr;
        end
    end

    // Wait, stall and error bookkeeping for the next edge.
    always_comb begin
        wait_d = wait_q;
        if (imem_ready) begin
            wait_d = '0;
        end else if (fsm_req) begin
            wait_d = wait_q + 1'b1;
        end

        stall_d = stall_q;
        if ((state_q == S_FETCH || state_q == S_BR_PEND) && fsm_freeze &&
            (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end

        terr_d = terr_q | wait_hit;
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            br_q    <= '0;
            wait_q  <= '0;
            stall_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            br_q    <= br_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            terr_q  <= terr_d;
        end
    end

    assign stall_cnt   = stall_q;
    assign timeout_err = terr_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed steps followed by random traffic, all
// checked against a behavioural model, plus a narrow-counter instance for
// stall_cnt saturation.
module tb_fetch_ctrl;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        hazard = 1'b0;
    logic        imem_ready = 1'b0;
    logic        imem_req, if_freeze, if_branch_taken, ifid_flush, timeout_err;
    logic [31:0] if_branch_addr;
    logic [15:0] stall_cnt;
    logic [1:0]  dbg_state;

    // Second instance: narrow stall counter, long timeout.
    logic        r2_rst = 1'b1;
    logic        r2_ready = 1'b0;
    logic        r2_req, r2_freeze, r2_brt, r2_flush, r2_terr;
    logic [31:0] r2_addr;
    logic [3:0]  r2_stall;
    logic [1:0]  r2_dbg;

    int n_checks = 0;
    int n_fails  = 0;

    // Clock
    always #5 clk = ~clk;

    fetch_ctrl #(.TIMEOUT(TO), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .branch_taken(branch_taken), .branch_addr(branch_addr),
        .hazard(hazard), .imem_ready(imem_ready), .imem_req(imem_req),
        .if_freeze(if_freeze), .if_branch_taken(if_branch_taken),
        .if_branch_addr(if_branch_addr), .ifid_flush(ifid_flush),
        .stall_cnt(stall_cnt), .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    fetch_ctrl #(.TIMEOUT(31), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(r2_rst), .branch_taken(1'b0), .branch_addr(32'h0),
        .hazard(1'b0), .imem_ready(r2_ready), .imem_req(r2_req),
        .if_freeze(r2_freeze), .if_branch_taken(r2_brt),
        .if_branch_addr(r2_addr), .ifid_flush(r2_flush),
        .stall_cnt(r2_stall), .timeout_err(r2_terr), .dbg_state(r2_dbg)
    );

    // Behavioural model: flags describing where the fetcher is.
    bit          m_starting = 1'b1;  // first cycle after reset
    bit          m_dead     = 1'b0;  // memory timed out
    bit          m_has_tgt  = 1'b0;  // a branch target waits for memory
    logic [31:0] m_tgt      = '0;
    int          m_waits    = 0;
    int          m_stalls   = 0;
    bit          m_err_flag = 1'b0;

    logic        e_req, e_frz, e_brt, e_flush;
    logic [31:0] e_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_out(input logic r, input logic b, input logic [31:0] a,
                             input logic h, input logic y);
        e_req = 1'b0; e_frz = 1'b1; e_flush = 1'b1; e_brt = 1'b0; e_addr = a;
        if (r || m_starting || m_dead) return;
        e_req = 1'b1;
        if (m_has_tgt) begin
            e_addr = m_tgt;
            e_brt  = y;
            e_frz  = !y;
        end else if (b && y) begin
            e_brt = 1'b1; e_frz = 1'b0;
        end else if (b || !y) begin
            // frozen and flushed
        end else if (h) begin
            e_flush = 1'b0;
        end else begin
            e_frz = 1'b0; e_flush = 1'b0;
        end
    endtask

    task automatic model_edge(input logic r, input logic b, input logic [31:0] a,
                              input logic y);
        bit timed_out;
        if (r) begin
            m_starting = 1; m_dead = 0; m_has_tgt = 0; m_tgt = '0;
            m_waits = 0; m_stalls = 0; m_err_flag = 0;
            return;
        end
        if (!m_starting && !m_dead && e_frz && m_stalls < 65535) m_stalls++;
        timed_out = e_req && !y && (m_waits + 1 == TO);
        if (y) m_waits = 0; else if (e_req) m_waits++;
        if (m_starting) m_starting = 0;
        else if (m_dead) ;
        else if (timed_out) begin
            m_dead = 1; m_err_flag = 1; m_has_tgt = 0;
        end else if (m_has_tgt) begin
            if (y) m_has_tgt = 0;
        end else if (b && !y) begin
            m_has_tgt = 1; m_tgt = a;
        end
    endtask

    // One clock of stimulus: drive, compare against model, advance model.
    task automatic step(input logic r, input logic b, input logic [31:0] a,
                        input logic h, input logic y);
        @(negedge clk);
        rst = r; branch_taken = b; branch_addr = a; hazard = h; imem_ready = y;
        #1;
        model_out(r, b, a, h, y);
        chk("imem_req", 32'(imem_req), 32'(e_req));
        chk("if_freeze", 32'(if_freeze), 32'(e_frz));
        chk("if_branch_taken", 32'(if_branch_taken), 32'(e_brt));
        chk("if_branch_addr", if_branch_addr, e_addr);
        chk("ifid_flush", 32'(ifid_flush), 32'(e_flush));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
        chk("timeout_err", 32'(timeout_err), 32'(m_err_flag));
        @(posedge clk);
        model_edge(r, b, a, y);
    endtask

    initial begin
        // Reset
        step(1, 0, 32'h0, 0, 0);
        step(1, 1, 32'h1234, 1, 1);

        // Ready always high: one idle cycle, then no freezing
        for (int i = 0; i < 6; i++) step(0, 0, 32'h0, 0, 1);
        chk("idle_then_run_stall", 32'(stall_cnt), 32'd0);

        // Branch resolved with memory ready
        step(0, 1, 32'h40, 0, 1);
        chk("br_now_taken", 32'(if_branch_taken), 32'd1);
        chk("br_now_addr", if_branch_addr, 32'h40);

        // Branch parked while memory is busy; hazard/branch ignored meanwhile
        step(0, 1, 32'h80, 0, 0);
        step(0, 1, 32'h123, 1, 0);
        step(0, 0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 0, 1);
        chk("br_pend_taken", 32'(if_branch_taken), 32'd1);
        chk("br_pend_addr", if_branch_addr, 32'h80);
        chk("br_pend_stall", 32'(stall_cnt), 32'd3);

        // Load-use hazard for two cycles
        step(0, 0, 32'h0, 1, 1);
        step(0, 0, 32'h0, 1, 1);
        step(0, 0, 32'h0, 0, 1);
        chk("hazard_stall", 32'(stall_cnt), 32'd5);

        // Memory silent: error trap; branch on the trap cycle is dropped
        for (int i = 0; i < 14; i++) step(0, 0, 32'h0, 0, 0);
        step(0, 1, 32'h99, 0, 0);
        step(0, 1, 32'h55, 0, 1);
        chk("err_req", 32'(imem_req), 32'd0);
        chk("err_flag", 32'(timeout_err), 32'd1);
        step(0, 0, 32'h0, 1, 1);
        step(1, 0, 32'h0, 0, 1);
        step(0, 0, 32'h0, 0, 1);
        chk("after_rst_stall", 32'(stall_cnt), 32'd0);
        chk("after_rst_flag", 32'(timeout_err), 32'd0);

        // Random traffic, with a low-ready window to provoke timeouts
        for (int i = 0; i < 500; i++) begin
            logic y;
            if (i >= 250 && i < 350) y = ($urandom_range(0, 7) == 0);
            else                     y = ($urandom_range(0, 3) != 0);
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) == 0),
                 $urandom, ($urandom_range(0, 3) == 0), y);
        end

        // Saturation of a 4-bit stall counter
        step(1, 0, 32'h0, 0, 0);
        @(negedge clk);
        r2_rst = 1'b0; r2_ready = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            #1;
            chk("sat_stall", 32'(r2_stall), (k == 0) ? 32'd0 : 32'((k - 1 > 15) ? 15 : k - 1));
            @(negedge clk);
        end
        #1;
        chk("sat_final", 32'(r2_stall), 32'd15);
        chk("sat_no_err", 32'(r2_terr), 32'd0);
        chk("sat_req", 32'(r2_req), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
